univ_shift_reg: RTL and testbench

Parametrised universal shift register: the next step up from the single-bit DFF with reset. It holds a WIDTH-bit word and supports hold, parallel load, logical shift, rotate and arithmetic shift right, with serial in/out at both ends. An internal shift counter pulses `Done` after every WIDTH shifts, so the block works directly as a serialiser or deserialiser in the digital-systems task designs.

---
 rtl/univ_shift_reg_pkg.sv | 16 +
 rtl/univ_shift_reg_shift_cnt.sv | 39 +++
 rtl/univ_shift_reg.sv | 64 ++++++
 tb/tb_univ_shift_reg.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: operation codes shared by the universal shift register and its bench.
package univ_shift_reg_pkg;
    typedef enum logic [2:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ROL  = 3'd4,
        ROR  = 3'd5,
        ASR  = 3'd6
    } mode_t;

    function automatic logic is_shift(input mode_t m);
        return m inside {SHL, SHR, ROL, ROR, ASR};
    endfunction
endpackage

// File: rtl/univ_shift_reg_shift_cnt.sv
// shift_cnt: modulo-WIDTH shift counter with a registered rollover pulse.
// Ports: CLK, Reset (async), Clr (sync clear), Inc (count one shift),
//        Zero (restart the word), Count (shifts so far), Wrap (pulse on WIDTH-1 -> 0).
module shift_cnt #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Clr,
    input  logic          Inc,
    input  logic          Zero,
    output logic [CW-1:0] Count,
    output logic          Wrap
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;
    logic          last;

    assign last = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        cnt_d  = Inc ? (last ? '0 : cnt_q + 1'b1) : (Zero ? '0 : cnt_q);
        wrap_d = Inc && last;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset || Clr) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign Count = cnt_q;
    assign Wrap  = wrap_q;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with serial I/O and a word-done pulse.
// Ports: CLK, Reset (async), En (clock enable), Clr (sync clear), Mode (mode_t),
//        D (parallel load), SerInL/SerInR (serial in at MSB/LSB), Q (contents),
//        SerOutL/SerOutR (MSB/LSB of Q), ShiftCount (shifts this word), Done (word pulse).
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CW          = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             En,
    input  logic             Clr,
    input  mode_t            Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerInL,
    input  logic             SerInR,
    output logic [WIDTH-1:0] Q,
    output logic             SerOutL,
    output logic             SerOutR,
    output logic [CW-1:0]    ShiftCount,
    output logic             Done
);
    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        case (Mode)
            LOAD:    q_d = D;
            SHL:     q_d = {q_q[WIDTH-2:0], SerInR};
            SHR:     q_d = {SerInL, q_q[WIDTH-1:1]};
            ROL:     q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            ROR:     q_d = {q_q[0], q_q[WIDTH-1:1]};
            ASR:     q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            q_q <= RESET_VALUE;
        else if (Clr)
            q_q <= RESET_VALUE;
        else if (En)
            q_q <= q_d;
    end

    // Clr dominates inside the counter, so En gating alone qualifies a shift or load here.
    shift_cnt #(.WIDTH(WIDTH)) u_cnt (
        .CLK   (CLK),
        .Reset (Reset),
        .Clr   (Clr),
        .Inc   (En && is_shift(Mode)),
        .Zero  (En && Mode == LOAD),
        .Count (ShiftCount),
        .Wrap  (Done)
    );

    assign Q       = q_q;
    assign SerOutL = q_q[WIDTH-1];
    assign SerOutR = q_q[0];
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed self-checking bench for univ_shift_reg (WIDTH=8).
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       En = 1'b0;
    logic       Clr = 1'b0;
    mode_t      Mode = HOLD;
    logic [7:0] D = '0;
    logic       SerInL = 1'b0;
    logic       SerInR = 1'b0;
    logic [7:0] Q;
    logic       SerOutL, SerOutR;
    logic [2:0] ShiftCount;
    logic       Done;

    int errors = 0;
    int checks = 0;

    univ_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .CLK(CLK), .Reset(Reset), .En(En), .Clr(Clr), .Mode(Mode), .D(D),
        .SerInL(SerInL), .SerInR(SerInR), .Q(Q), .SerOutL(SerOutL),
        .SerOutR(SerOutR), .ShiftCount(ShiftCount), .Done(Done)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic en, input logic clr, input mode_t m,
                         input logic [7:0] d, input logic sl, input logic sr);
        @(negedge CLK);
        En = en; Clr = clr; Mode = m; D = d; SerInL = sl; SerInR = sr;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #1;
        if (Q !== 8'h00) begin $display("FAIL reset_q: got %h want 00", Q); errors++; end
        checks++;
        if (ShiftCount !== 3'd0 || Done !== 1'b0) begin
            $display("FAIL reset_cnt: got cnt=%0d done=%b want 0/0", ShiftCount, Done); errors++;
        end
        checks++;
        @(negedge CLK);
        Reset = 1'b0;
        drive(1, 0, LOAD, 8'hA5, 0, 0);
        drive(1, 0, SHL, 8'h00, 0, 0);
        if (Q !== 8'h4A || ShiftCount !== 3'd1) begin
            $display("FAIL pre_reset: got q=%h cnt=%0d want 4a/1", Q, ShiftCount); errors++;
        end
        checks++;
        drive(1, 0, LOAD, 8'hA5, 0, 0);
        @(negedge CLK);
        En = 1'b0;
        #2 Reset = 1'b1;
        #1;
        if (Q !== 8'h00 || ShiftCount !== 3'd0 || Done !== 1'b0) begin
            $display("FAIL async_reset: got q=%h cnt=%0d done=%b want 00/0/0", Q, ShiftCount, Done);
            errors++;
        end
        checks++;
        Reset = 1'b0;
    endtask

    task automatic test_rol();
        logic [7:0] exp [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        drive(1, 0, LOAD, 8'h81, 0, 0);
        if (Q !== 8'h81 || ShiftCount !== 3'd0) begin
            $display("FAIL rol_load: got q=%h cnt=%0d want 81/0", Q, ShiftCount); errors++;
        end
        checks++;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, ROL, 8'h00, 0, 0);
            if (Q !== exp[i] || Done !== (i == 7) || ShiftCount !== 3'((i + 1) % 8)) begin
                $display("FAIL rol_step%0d: got q=%h done=%b cnt=%0d want %h/%b/%0d",
                         i, Q, Done, ShiftCount, exp[i], i == 7, (i + 1) % 8);
                errors++;
            end
            checks++;
        end
        drive(1, 0, HOLD, 8'h00, 0, 0);
        if (Done !== 1'b0 || Q !== 8'h81) begin
            $display("FAIL rol_done_pulse: got done=%b q=%h want 0/81", Done, Q); errors++;
        end
        checks++;
    endtask

    task automatic test_deserialise();
        logic [7:0] bits = 8'b1011_0010;
        drive(1, 0, LOAD, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, SHL, 8'h00, 0, bits[7 - i]);
            if (Done !== (i == 7)) begin
                $display("FAIL shl_done%0d: got %b want %b", i, Done, i == 7); errors++;
            end
            checks++;
        end
        if (Q !== 8'hB2) begin $display("FAIL shl_word: got %h want b2", Q); errors++; end
        checks++;
        drive(1, 0, LOAD, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, SHR, 8'h00, 1, 0);
        if (Q !== 8'hE0 || SerOutL !== 1'b1 || ShiftCount !== 3'd3) begin
            $display("FAIL shr_word: got q=%h sol=%b cnt=%0d want e0/1/3", Q, SerOutL, ShiftCount);
            errors++;
        end
        checks++;
    endtask

    task automatic test_asr_ror();
        drive(1, 0, LOAD, 8'h90, 0, 0);
        drive(1, 0, ASR, 8'h00, 0, 0);
        if (Q !== 8'hC8 || SerOutL !== 1'b1 || SerOutR !== 1'b0) begin
            $display("FAIL asr: got q=%h sol=%b sor=%b want c8/1/0", Q, SerOutL, SerOutR); errors++;
        end
        checks++;
        drive(1, 0, ROR, 8'h00, 0, 0);
        if (Q !== 8'h64 || SerOutR !== 1'b0) begin
            $display("FAIL ror1: got q=%h sor=%b want 64/0", Q, SerOutR); errors++;
        end
        checks++;
        drive(1, 0, ROR, 8'h00, 0, 0);
        drive(1, 0, ROR, 8'h00, 0, 0);
        if (Q !== 8'h19 || SerOutR !== 1'b1 || SerOutL !== 1'b0) begin
            $display("FAIL ror3: got q=%h sor=%b sol=%b want 19/1/0", Q, SerOutR, SerOutL); errors++;
        end
        checks++;
    endtask

    task automatic test_enable_clear();
        drive(1, 0, LOAD, 8'h5A, 0, 0);
        drive(1, 0, SHL, 8'h00, 0, 0);
        drive(1, 0, SHL, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, SHL, 8'h00, 1, 1);
        if (Q !== 8'h68 || ShiftCount !== 3'd2 || Done !== 1'b0) begin
            $display("FAIL en_low: got q=%h cnt=%0d done=%b want 68/2/0", Q, ShiftCount, Done); errors++;
        end
        checks++;
        drive(0, 1, SHL, 8'h00, 0, 0);
        if (Q !== 8'h00 || ShiftCount !== 3'd0) begin
            $display("FAIL clr_en_low: got q=%h cnt=%0d want 00/0", Q, ShiftCount); errors++;
        end
        checks++;
        drive(1, 1, LOAD, 8'hFF, 0, 0);
        if (Q !== 8'h00) begin $display("FAIL clr_over_load: got %h want 00", Q); errors++; end
        checks++;
    endtask

    task automatic test_midword();
        drive(1, 0, LOAD, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 0, SHL, 8'h00, 0, 1);
        if (ShiftCount !== 3'd5 || Q !== 8'h1F) begin
            $display("FAIL mid_shift: got cnt=%0d q=%h want 5/1f", ShiftCount, Q); errors++;
        end
        checks++;
        drive(1, 0, LOAD, 8'h3C, 0, 0);
        if (ShiftCount !== 3'd0 || Done !== 1'b0) begin
            $display("FAIL mid_load: got cnt=%0d done=%b want 0/0", ShiftCount, Done); errors++;
        end
        checks++;
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, ROL, 8'h00, 0, 0);
            if (Done !== 1'b0 || ShiftCount !== 3'(i + 1)) begin
                $display("FAIL mid_rol%0d: got done=%b cnt=%0d want 0/%0d", i, Done, ShiftCount, i + 1);
                errors++;
            end
            checks++;
        end
        drive(1, 0, mode_t'(3'd7), 8'hFF, 1, 1);
        if (Q !== 8'h1E || ShiftCount !== 3'd7 || Done !== 1'b0) begin
            $display("FAIL reserved: got q=%h cnt=%0d done=%b want 1e/7/0", Q, ShiftCount, Done); errors++;
        end
        checks++;
        drive(1, 0, ROL, 8'h00, 0, 0);
        if (Q !== 8'h3C || ShiftCount !== 3'd0 || Done !== 1'b1) begin
            $display("FAIL mid_wrap: got q=%h cnt=%0d done=%b want 3c/0/1", Q, ShiftCount, Done); errors++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_rol();
        test_deserialise();
        test_asr_ror();
        test_enable_clear();
        test_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
